// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - state type and width constants shared by the shift-subtract divider
package divider_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int ITER_N     = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/divider_controller.sv
// rtl/divider_controller.sv - divider FSM and iteration counter
// DIVIDER_ZERO_DETECT_EN: a zero divisor skips straight from LOAD to DONE.
module divider_controller
  import divider_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic zero_div,
  output logic ld_ops,
  output logic init,
  output logic step,
  output logic ld_out,
  output logic busy,
  output logic done
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic               w_last;
  logic               w_zero_exit;

`ifdef DIVIDER_ZERO_DETECT_EN
  assign w_zero_exit = zero_div;
`else
  logic w_unused_zero_div;
  assign w_unused_zero_div = zero_div;
  assign w_zero_exit       = 1'b0;
`endif

  assign w_last = (r_cnt == CNT_W'(ITER_N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) r_state <= LOAD;
        LOAD: begin
          r_cnt <= '0;
          if (w_zero_exit) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ITER;
          end
        end
        ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Results are written on the edge entering DONE so they are visible with done.
  assign ld_ops = (r_state == IDLE) && start;
  assign init   = (r_state == LOAD);
  assign step   = (r_state == ITER);
  assign ld_out = (step && w_last) || (init && w_zero_exit);
  assign busy   = (r_state != IDLE);
  assign done   = r_done;

endmodule

// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - 8-bit by 4-bit restoring divider, one quotient bit per clock
// DIVIDER_ZERO_DETECT_EN: enables early exit and the div_by_zero flag.
module shift_sub_divider
  import divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W:0]    r_rem;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_remd;

  logic                  w_ld_ops, w_init, w_step, w_ld_out, w_zero_div;
  logic [DIVISOR_W:0]    w_r_shift, w_r_next;
  logic [DIVIDEND_W-1:0] w_q_next;
  logic                  w_ge;
  logic                  w_unused_rem_msb;

  divider_controller u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .zero_div (w_zero_div),
    .ld_ops   (w_ld_ops),
    .init     (w_init),
    .step     (w_step),
    .ld_out   (w_ld_out),
    .busy     (busy),
    .done     (done)
  );

  assign w_zero_div = (r_dvs == '0);

  // R[4] only matters for the compare; it is shifted out before the next step.
  assign w_r_shift        = {r_rem[DIVISOR_W-1:0], r_q[DIVIDEND_W-1]};
  assign w_ge             = (w_r_shift >= {1'b0, r_dvs});
  assign w_r_next         = w_ge ? (w_r_shift - {1'b0, r_dvs}) : w_r_shift;
  assign w_q_next         = {r_q[DIVIDEND_W-2:0], w_ge};
  assign w_unused_rem_msb = r_rem[DIVISOR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_quot <= '0;
      r_remd <= '0;
    end else begin
      if (w_ld_ops) begin
        r_dvd <= dividend;
        r_dvs <= divisor;
      end
      if (w_init) begin
        r_rem <= '0;
        r_q   <= r_dvd;
      end else if (w_step) begin
        r_rem <= w_r_next;
        r_q   <= w_q_next;
      end
      if (w_ld_out) begin
        if (w_init) begin
          r_quot <= '1;
          r_remd <= r_dvd[DIVISOR_W-1:0];
        end else begin
          r_quot <= w_q_next;
          r_remd <= w_r_next[DIVISOR_W-1:0];
        end
      end
    end
  end

`ifdef DIVIDER_ZERO_DETECT_EN
  logic r_dbz;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbz <= 1'b0;
    end else if (w_ld_out) begin
      r_dbz <= w_init;
    end
  end
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  assign quotient  = r_quot;
  assign remainder = r_remd;

endmodule
